dm_access_stage: RTL and testbench
==================================

# dm_access_stage

Data-memory access stage of the 5-stage pipeline, directly downstream of the EX/DM pipeline register. It consumes that register's outputs (memory address, store data, read/write strobes, mem-to-reg select), performs a word access to an internal data RAM with a configurable number of wait states, and stalls the upstream pipeline while the access is in flight. It registers the results for write-back, so it also acts as the DM/WB latch.

## Interface
- DEPTH_WORDS, 256: data RAM depth in 32-bit words. Power of two, ≥ 4.
- WAIT_STATES, 2: extra cycles per memory access. Range 0..15.

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Mem_read  in  1  load request
- Mem_write  in  1  store request
- Mem_address  in  32  byte address; doubles as the ALU result
- Write_data  in  32  store data
- mem_to_reg_in  in  1  write-back select
- dm_stall  out  1  combinational; upstream holds all inputs while high
- Read_data  out  32  registered load data
- Alu_result_out  out  32  registered copy of Mem_address
- mem_to_reg_out  out  1  registered select
- wb_valid  out  1  registered; outputs carry a completed instruction
- mem_fault  out  1  registered; one-cycle flag for a misaligned or out-of-range access

## Operation
- Word index: idx = Mem_address[log2(DEPTH_WORDS)+1:2].
- Access is legal when Mem_address[1:0] == 0 and Mem_address[31:log2(DEPTH_WORDS)+2] == 0.
- If Mem_read and Mem_write are both high, the instruction is a store. Read_data is 0.
- Non-memory instruction (neither strobe high): completes in one cycle with no stall.
  - wb_valid = 1, Read_data = 0.
  - Alu_result_out and mem_to_reg_out are passed through.
- Illegal memory access: completes in one cycle with no stall and no RAM change.
  - Read_data = 0, mem_fault = 1, wb_valid = 1.
- FSM states: IDLE, WAIT.
  - In IDLE with a legal access and WAIT_STATES > 0: load cnt = WAIT_STATES − 1 and go to WAIT.
  - In WAIT with cnt > 0: decrement cnt.
  - In WAIT with cnt == 0: go to IDLE.
- dm_stall = (IDLE & legal access & WAIT_STATES > 0) | (WAIT & cnt != 0).
- The access completes on the edge that ends the last cycle in which dm_stall is low. At that edge:
  - Store: RAM[idx] ← Write_data.
  - Load: Read_data ← RAM[idx].
  - wb_valid ← 1.
- On every edge where dm_stall is high, the outputs take bubble values: wb_valid = 0, mem_to_reg_out = 0, mem_fault = 0, Read_data = 0. The RAM is unchanged.
- Reset:
  - Asserted: FSM goes to IDLE, cnt = 0, and all outputs go to 0 (dm_stall follows, so it is 0).
  - Mid-access: the in-flight access is aborted and no RAM write occurs.
  - RAM contents are not affected by reset.

## Timing
- Latency of a legal memory access is WAIT_STATES + 1 cycles from first presentation. dm_stall is high for the first WAIT_STATES of those cycles.
- With WAIT_STATES = 0 the FSM never leaves IDLE, every instruction takes one cycle, and dm_stall is constantly 0.
- Back-to-back accesses are accepted: after WAIT returns to IDLE, the next instruction is evaluated in that same cycle.
- Inputs that change while dm_stall is high violate the protocol. Behaviour in that case is undefined; the bench asserts on it.
- A store followed immediately by a load to the same idx returns the new data, because the write completes before the load is sampled.

## Test plan
- Reset, then non-memory instruction with Mem_address = 0x1234 and mem_to_reg_in = 0 -> next cycle wb_valid = 1, Alu_result_out = 0x1234, no stall.
- WAIT_STATES = 2: store 0xDEADBEEF to 0x10, then load 0x10 with mem_to_reg_in = 1 -> each access stalls 2 cycles, write-back is bubbled during the stalls, and the load gives Read_data = 0xDEADBEEF, mem_to_reg_out = 1.
- Load 0x13 (misaligned), then load 0x400 (out of range for DEPTH 256) -> each gives mem_fault = 1, Read_data = 0, no stall; the RAM is unchanged.
- Both strobes high to 0x20 with data 0x5 -> treated as a store, Read_data = 0; a later load of 0x20 returns 0x5.
- Assert rst_n low during the WAIT cycle of a store to 0x30 -> outputs go to 0 immediately; a later load of 0x30 returns the old value.
- WAIT_STATES = 0: 8 alternating stores and loads -> dm_stall is never high and one instruction completes per cycle.

Source files
------------

// File: rtl/dm_access_stage.sv
// Data-memory access stage and DM/WB latch: word access to an internal RAM with
// configurable wait states, stalling upstream while an access is in flight.
module dm_access_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic [31:0] Mem_address,
    input  logic [31:0] Write_data,
    input  logic        mem_to_reg_in,
    output logic        dm_stall,
    output logic [31:0] Read_data,
    output logic [31:0] Alu_result_out,
    output logic        mem_to_reg_out,
    output logic        wb_valid,
    output logic        mem_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stall;
    logic [31:0] ram_q [DEPTH_WORDS];

    logic [31:0] read_data_q;
    logic [31:0] alu_result_q;
    logic        mem_to_reg_q;
    logic        wb_valid_q;
    logic        mem_fault_q;

    logic [AW-1:0] idx;
    logic          legal;
    logic          memOp;
    logic          accessOk;
    logic          isLoad;
    logic          ramWe;

    assign idx      = Mem_address[AW+1:2];
    assign legal    = (Mem_address[1:0] == 2'b00) && (Mem_address[31:AW+2] == '0);
    assign memOp    = Mem_read | Mem_write;
    assign accessOk = memOp & legal;
    assign isLoad   = Mem_read & ~Mem_write;

    // A memory write only ever happens on the completing edge, so an access
    // aborted by reset never reaches the RAM.
    assign ramWe    = rst_n & ~stall & accessOk & Mem_write;
    assign dm_stall = stall & rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accessOk && (WAIT_STATES > 0)) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = WS_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram_q[idx] <= Write_data;
        end
    end

    // While stalled the write-back latch carries a bubble; otherwise it captures
    // the completing instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            mem_to_reg_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            mem_fault_q  <= 1'b0;
        end else if (stall) begin
            read_data_q  <= 32'd0;
            alu_result_q <= Mem_address;
            mem_to_reg_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            mem_fault_q  <= 1'b0;
        end else begin
            read_data_q  <= (isLoad && legal) ? ram_q[idx] : 32'd0;
            alu_result_q <= Mem_address;
            mem_to_reg_q <= mem_to_reg_in;
            wb_valid_q   <= 1'b1;
            mem_fault_q  <= memOp & ~legal;
        end
    end

    assign Read_data      = read_data_q;
    assign Alu_result_out = alu_result_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign wb_valid       = wb_valid_q;
    assign mem_fault      = mem_fault_q;

endmodule

// File: tb/tb_dm_access_stage.sv
// Scoreboard bench for dm_access_stage: one instance with two wait states and
// one with none, each checked against a small RAM model.
module tb_dm_access_stage;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        memRead2, memWrite2, m2rIn2;
    logic [31:0] addr2, wdata2;
    logic        dmStall2, m2rOut2, wbValid2, fault2;
    logic [31:0] rdata2, alu2;

    logic        memRead0, memWrite0, m2rIn0;
    logic [31:0] addr0, wdata0;
    logic        dmStall0, m2rOut0, wbValid0, fault0;
    logic [31:0] rdata0, alu0;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] model2 [256];
    logic [31:0] model0 [256];
    bit          active2;
    bit          active0;
    int          nChecks;
    int          nFails;
    logic        stallPrev;
    logic [66:0] inPrev;

    dm_access_stage #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .Mem_read(memRead2), .Mem_write(memWrite2),
        .Mem_address(addr2), .Write_data(wdata2), .mem_to_reg_in(m2rIn2),
        .dm_stall(dmStall2), .Read_data(rdata2), .Alu_result_out(alu2),
        .mem_to_reg_out(m2rOut2), .wb_valid(wbValid2), .mem_fault(fault2)
    );

    dm_access_stage #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .Mem_read(memRead0), .Mem_write(memWrite0),
        .Mem_address(addr0), .Write_data(wdata0), .mem_to_reg_in(m2rIn0),
        .dm_stall(dmStall0), .Read_data(rdata0), .Alu_result_out(alu0),
        .mem_to_reg_out(m2rOut0), .wb_valid(wbValid0), .mem_fault(fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Inputs must stay frozen across any edge at which the stage was stalling.
    always @(posedge clk) begin
        if (rst_n && stallPrev) begin
            assert ({memRead2, memWrite2, addr2, wdata2, m2rIn2} == inPrev)
                else $error("[TB] protocol violation: inputs changed while dm_stall high");
        end
        stallPrev <= dmStall2;
        inPrev    <= {memRead2, memWrite2, addr2, wdata2, m2rIn2};
    end

    always @(posedge clk) begin : mon2
        exp_t e;
        #1;
        if (rst_n && active2 && wbValid2) begin
            if (q2.size() == 0) begin
                checkOutput("ws2_unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                checkOutput("ws2_alu", alu2, e.alu);
                checkOutput("ws2_rdata", rdata2, e.rdata);
                checkOutput("ws2_m2r", {31'd0, m2rOut2}, {31'd0, e.m2r});
                checkOutput("ws2_fault", {31'd0, fault2}, {31'd0, e.fault});
            end
        end
    end

    always @(posedge clk) begin : mon0
        exp_t e;
        #1;
        if (rst_n && active0 && wbValid0) begin
            if (q0.size() == 0) begin
                checkOutput("ws0_unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                checkOutput("ws0_alu", alu0, e.alu);
                checkOutput("ws0_rdata", rdata0, e.rdata);
                checkOutput("ws0_m2r", {31'd0, m2rOut0}, {31'd0, e.m2r});
                checkOutput("ws0_fault", {31'd0, fault0}, {31'd0, e.fault});
            end
        end
    end

    // Called 2 time units after a rising edge; returns at the same phase after
    // the edge on which the instruction completes.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic m2r);
        exp_t e;
        bit   legal;
        bit   memOp;
        bit   done;
        int   expStalls;
        int   stalls;
        memRead2  = rd;
        memWrite2 = wr;
        addr2     = addr;
        wdata2    = data;
        m2rIn2    = m2r;
        legal     = (addr[1:0] == 2'b00) && (addr[31:10] == 22'd0);
        memOp     = rd || wr;
        expStalls = (memOp && legal) ? 2 : 0;
        e.alu     = addr;
        e.m2r     = m2r;
        e.fault   = memOp && !legal;
        e.rdata   = (rd && !wr && legal) ? model2[addr[9:2]] : 32'd0;
        if (wr && legal) model2[addr[9:2]] = data;
        q2.push_back(e);
        stalls = 0;
        done   = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (dmStall2) begin
                stalls++;
                @(posedge clk);
                #2;
                checkOutput("bubble_wb", {31'd0, wbValid2}, 32'd0);
                checkOutput("bubble_rdata", rdata2, 32'd0);
                checkOutput("bubble_m2r", {31'd0, m2rOut2}, 32'd0);
                checkOutput("bubble_fault", {31'd0, fault2}, 32'd0);
            end else begin
                @(posedge clk);
                #2;
                done = 1;
            end
        end
        checkOutput("stall_cycles", stalls, expStalls);
    endtask

    task automatic applyStimulus0(input int i);
        exp_t        e;
        logic [31:0] addr;
        addr      = 32'h40 + 32'(4 * (i / 2));
        memRead0  = (i % 2) == 1;
        memWrite0 = (i % 2) == 0;
        addr0     = addr;
        wdata0    = 32'hA5A50000 + 32'(i);
        m2rIn0    = (i % 2) == 1;
        e.alu     = addr;
        e.m2r     = m2rIn0;
        e.fault   = 1'b0;
        e.rdata   = memRead0 ? model0[addr[9:2]] : 32'd0;
        if (memWrite0) model0[addr[9:2]] = wdata0;
        q0.push_back(e);
        #1;
        checkOutput("ws0_stall", {31'd0, dmStall0}, 32'd0);
        @(posedge clk);
        #2;
        checkOutput("ws0_wb_every_cycle", {31'd0, wbValid0}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nChecks = 0;
        nFails  = 0;
        active2 = 0;
        active0 = 0;
        rst_n   = 1'b0;
        {memRead2, memWrite2, m2rIn2, addr2, wdata2} = '0;
        {memRead0, memWrite0, m2rIn0, addr0, wdata0} = '0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_wb", {31'd0, wbValid2}, 32'd0);
        checkOutput("reset_rdata", rdata2, 32'd0);
        checkOutput("reset_alu", alu2, 32'd0);
        checkOutput("reset_m2r", {31'd0, m2rOut2}, 32'd0);
        checkOutput("reset_fault", {31'd0, fault2}, 32'd0);
        checkOutput("reset_stall", {31'd0, dmStall2}, 32'd0);
        checkOutput("reset_wb_ws0", {31'd0, wbValid0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #2;
        active2 = 1;

        applyStimulus(1'b0, 1'b0, 32'h1234, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h13, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h400, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h11, 32'h00000BAD, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h5, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0);

        // Abort a store to 0x30 while it sits in WAIT.
        active2   = 0;
        memRead2  = 1'b0;
        memWrite2 = 1'b1;
        addr2     = 32'h30;
        wdata2    = 32'h22222222;
        m2rIn2    = 1'b0;
        #1;
        checkOutput("abort_stall_before", {31'd0, dmStall2}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_wb", {31'd0, wbValid2}, 32'd0);
        checkOutput("abort_rdata", rdata2, 32'd0);
        checkOutput("abort_alu", alu2, 32'd0);
        checkOutput("abort_m2r", {31'd0, m2rOut2}, 32'd0);
        checkOutput("abort_fault", {31'd0, fault2}, 32'd0);
        checkOutput("abort_stall", {31'd0, dmStall2}, 32'd0);
        {memRead2, memWrite2, m2rIn2, addr2, wdata2} = '0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #2;
        active2 = 1;
        applyStimulus(1'b1, 1'b0, 32'h30, 32'd0, 1'b1);
        active2 = 0;
        {memRead2, memWrite2, m2rIn2, addr2, wdata2} = '0;
        checkOutput("ws2_queue_drained", q2.size(), 32'd0);

        active0 = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus0(i);
        end
        active0 = 0;
        {memRead0, memWrite0, m2rIn0, addr0, wdata0} = '0;
        checkOutput("ws0_queue_drained", q0.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
